// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: snapshots a tap bus and runs one shared signed MAC per tap, then scales and saturates the sum.
module fir_mac_sequencer #(
   parameter int TOTAL_TAPS   = 9,
   parameter int BITS_PER_TAP = 8,
   parameter int COEFF_BITS   = 8,
   parameter int ACC_BITS     = 20,
   parameter int SHIFT        = 7,
   parameter int OUT_BITS     = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_start_calc,
   input  logic [TOTAL_TAPS*BITS_PER_TAP-1:0] i_taps,
   input  logic [TOTAL_TAPS*COEFF_BITS-1:0]   i_coeffs,
   output logic [OUT_BITS-1:0]                o_value,
   output logic                               o_valid,
   output logic                               o_busy,
   output logic                               o_overrun
);
   localparam int IW = TOTAL_TAPS > 1 ? $clog2(TOTAL_TAPS) : 1;
   localparam int PW = BITS_PER_TAP + COEFF_BITS;
   localparam logic signed [ACC_BITS-1:0] OMAX = {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] OMIN = ~OMAX;
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic signed [ACC_BITS-1:0] acc_q, acc_d, s;
   logic [TOTAL_TAPS*BITS_PER_TAP-1:0] snap_q, snap_d;
   logic [OUT_BITS-1:0] value_q, value_d;
   logic valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;
   logic signed [BITS_PER_TAP-1:0] tap;
   logic signed [COEFF_BITS-1:0] coef;
   logic signed [PW-1:0] prod;
   always_comb begin
      tap = snap_q[idx_q*BITS_PER_TAP +: BITS_PER_TAP];
      coef = i_coeffs[idx_q*COEFF_BITS +: COEFF_BITS];
      prod = tap * coef;
      s = acc_q >>> SHIFT;
      state_d = state_q;
      idx_d = idx_q;
      acc_d = acc_q;
      snap_d = snap_q;
      value_d = value_q;
      valid_d = 1'b0;
      busy_d = busy_q;
      ovr_d = ovr_q | (i_start_calc && state_q != IDLE);
      case (state_q)
         IDLE: if (i_start_calc) begin
            snap_d = i_taps;
            acc_d = '0;
            idx_d = '0;
            busy_d = 1'b1;
            state_d = MAC;
         end
         MAC: begin
            acc_d = acc_q + {{(ACC_BITS-PW){prod[PW-1]}}, prod};
            idx_d = idx_q + 1'b1;
            state_d = idx_q == IW'(TOTAL_TAPS-1) ? DONE : MAC;
         end
         DONE: begin
            value_d = s > OMAX ? OMAX[OUT_BITS-1:0] : s < OMIN ? OMIN[OUT_BITS-1:0] : s[OUT_BITS-1:0];
            valid_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q <= '0;
         acc_q <= '0;
         snap_q <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         busy_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         acc_q <= acc_d;
         snap_q <= snap_d;
         value_q <= value_d;
         valid_q <= valid_d;
         busy_q <= busy_d;
         ovr_q <= ovr_d;
      end
   end
   assign o_value = value_q;
   assign o_valid = valid_q;
   assign o_busy = busy_q;
   assign o_overrun = ovr_q;
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR controller for one wavelet filter stage, sitting downstream of the tap shift-register line.
- On each start-of-calculation pulse it snapshots the tap bus, then steps one shared multiply-accumulate unit through all taps against a coefficient bus, one tap per clk.
- It then scales and saturates the sum and emits one result with a single-cycle valid strobe.
- Replaces TOTAL_TAPS parallel multipliers with one.

Parameters:
- TOTAL_TAPS, 9: number of taps and coefficients.
- BITS_PER_TAP, 8: signed width of each tap sample.
- COEFF_BITS, 8: signed width of each coefficient.
- ACC_BITS, 20: signed accumulator width. Must be at least BITS_PER_TAP+COEFF_BITS+clog2(TOTAL_TAPS).
- SHIFT, 7: arithmetic right shift applied to the accumulator before saturation.
- OUT_BITS, 8: signed output width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- i_start_calc  in  1  one-cycle pulse from the tap line: taps are valid this cycle.
- i_taps  in  TOTAL_TAPS*BITS_PER_TAP  tap bus. Tap k occupies bits [k*BITS_PER_TAP +: BITS_PER_TAP]; tap 0 is the newest sample.
- i_coeffs  in  TOTAL_TAPS*COEFF_BITS  coefficient bus, same slicing. Treated as static while o_busy=1.
- o_value  out  OUT_BITS  signed filter result. Holds its value until the next result.
- o_valid  out  1  one-cycle strobe: o_value updated.
- o_busy  out  1  high while a calculation is in progress.
- o_overrun  out  1  sticky flag: a start pulse was dropped.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, state IDLE, accumulator 0, index 0, snapshot 0. Reset wins over every other event, including mid-calculation; the in-flight result is discarded and no o_valid is produced.
- FSM states: IDLE, MAC, DONE.
- IDLE, i_start_calc=1:
  - copy i_taps into an internal snapshot register (the tap line may shift afterwards without effect);
  - clear accumulator, index <= 0, o_busy <= 1, go to MAC.
- IDLE, i_start_calc=0: hold.
- MAC, each cycle:
  - acc <= acc + sext(snap[index]) * sext(coeff[index]), full-precision signed product, sign-extended to ACC_BITS;
  - index <= index+1;
  - when index == TOTAL_TAPS-1, go to DONE (exactly TOTAL_TAPS MAC cycles).
- DONE, one cycle:
  - s = acc >>> SHIFT (arithmetic, floor toward -inf, no rounding);
  - o_value <= s clamped to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1];
  - o_valid <= 1, o_busy <= 0, go to IDLE.
- o_valid is 0 in every other cycle.
- Latency: start sampled in cycle 0 -> o_valid high in cycle TOTAL_TAPS+2 (cycle 11 for defaults).
- o_busy is high from cycle 1 through cycle TOTAL_TAPS+1 inclusive.
- Start pulse while in MAC or DONE:
  - ignored; the current calculation is unaffected;
  - o_overrun <= 1 and stays 1 until reset.
- A start in the same cycle o_valid is high is accepted, since the state is IDLE then. Minimum start-to-start spacing without overrun is TOTAL_TAPS+2 cycles.
- i_start_calc held high for several cycles: the first cycle starts the calculation; the following cycles count as overrun.
- Accumulator never wraps for legal parameters; the bench flags any violation of the ACC_BITS rule.

Test Plan:
- Impulse: tap0=100, others 0; coeff0=64, others 0; start in cycle 0 -> o_valid only in cycle 11, o_value=50 (6400>>>7), o_busy high cycles 1-10, o_overrun=0.
- Positive saturation: all taps 127, all coeffs 127 -> acc=145161, 145161>>>7=1134, o_value=127.
- Negative saturation and floor:
  - all taps -128, all coeffs 127 -> o_value=-128;
  - tap0=-1, coeff0=1, others 0 -> o_value=-1.
- Snapshot isolation: start with tap0=100 (coeffs as in the impulse test), then change i_taps to all 0 in cycle 1 -> o_value still 50.
- Overrun and back-to-back:
  - start at cycle 0, second start at cycle 5 -> single o_valid at cycle 11, o_overrun=1 from cycle 6, held;
  - start at cycle 11 -> accepted, next o_valid at cycle 22.
- Reset mid-operation: start at cycle 0, rst=0 in cycle 4 -> o_busy=0 and all outputs 0 from cycle 5, no o_valid in cycles 5-15; a fresh start after rst=1 completes normally.
